// File: rtl/pipe_pattern_engine.sv
// Pattern generator (pipe-out) and checker (pipe-in) with per-direction throttle.
// Define PIPE_ENGINE_FIRST_ERR_EN to build first-error capture registers.
module pipe_pattern_engine #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            pattern,
   input  logic                  throttle_set,
   input  logic [31:0]           throttle_in_val,
   input  logic [31:0]           throttle_out_val,
   input  logic                  in_write,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic                  out_read,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_ready,
   output logic [31:0]           error_count,
   output logic [31:0]           in_word_count,
   output logic [31:0]           out_word_count,
   output logic                  first_err_valid,
   output logic [31:0]           first_err_index,
   output logic [DATA_WIDTH-1:0] first_err_expected,
   output logic [DATA_WIDTH-1:0] first_err_received
);

   localparam int LANES = DATA_WIDTH / 32;

   localparam logic [1:0] P_COUNT = 2'd0;
   localparam logic [1:0] P_LFSR  = 2'd1;
   localparam logic [1:0] P_WALK  = 2'd2;
   localparam logic [1:0] P_ALT   = 2'd3;

   function automatic logic [DATA_WIDTH-1:0] word0(input logic [1:0] p);
      logic [DATA_WIDTH-1:0] w;
      w = '0;
      for (int l = 0; l < LANES; l++) begin
         case (p)
            P_COUNT: w[32*l +: 32] = 32'(l);
            P_LFSR:  w[32*l +: 32] = 32'h0D0C0B0A ^ 32'(l);
            P_WALK:  w[32*l +: 32] = 32'd1 << (l % 32);
            default: w[32*l +: 32] = 32'hA5A55A5A;
         endcase
      end
      return w;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] next_word(
      input logic [1:0]            p,
      input logic [DATA_WIDTH-1:0] w
   );
      logic [DATA_WIDTH-1:0] r;
      logic [31:0]           s;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         s = w[32*l +: 32];
         case (p)
            P_COUNT: r[32*l +: 32] = s + 32'(LANES);
            P_LFSR:  r[32*l +: 32] = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
            P_WALK:  r[32*l +: 32] = {s[30:0], s[31]};
            default: r[32*l +: 32] = ~s;
         endcase
      end
      return r;
   endfunction

   logic [1:0]            pat_sel;
   logic [1:0]            pat_q;
   logic [DATA_WIDTH-1:0] gen_q, gen_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic [31:0]           out_cnt_q, out_cnt_d;
   logic [31:0]           in_cnt_q, in_cnt_d;
   logic [31:0]           err_q, err_d;
   logic [31:0]           thr_in_q, thr_in_d;
   logic [31:0]           thr_out_q, thr_out_d;
   logic                  in_rdy_q, out_rdy_q;
   logic                  mismatch;

   // Codes 4-7 fold onto the count pattern.
   always_comb begin
      pat_sel = pattern[2] ? P_COUNT : pattern[1:0];
   end

   assign mismatch = (in_data != exp_q);

   // Generator/checker advance and statistics next-state.
   always_comb begin
      gen_d     = gen_q;
      out_cnt_d = out_cnt_q;
      exp_d     = exp_q;
      in_cnt_d  = in_cnt_q;
      err_d     = err_q;
      if (out_read) begin
         gen_d     = next_word(pat_q, gen_q);
         out_cnt_d = out_cnt_q + 32'd1;
      end
      if (in_write) begin
         exp_d    = next_word(pat_q, exp_q);
         in_cnt_d = in_cnt_q + 32'd1;
         if (mismatch && (err_q != 32'hFFFFFFFF))
            err_d = err_q + 32'd1;
      end
   end

   // Throttle masks shift toward bit 0 so ready walks M[0], M[1], ...
   always_comb begin
      thr_in_d  = {thr_in_q[0], thr_in_q[31:1]};
      thr_out_d = {thr_out_q[0], thr_out_q[31:1]};
      if (throttle_set) begin
         thr_in_d  = throttle_in_val;
         thr_out_d = throttle_out_val;
      end
   end

   // Main state registers; reset beats every strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q     <= pat_sel;
         gen_q     <= word0(pat_sel);
         exp_q     <= word0(pat_sel);
         out_cnt_q <= '0;
         in_cnt_q  <= '0;
         err_q     <= '0;
         thr_in_q  <= '1;
         thr_out_q <= '1;
         in_rdy_q  <= 1'b1;
         out_rdy_q <= 1'b1;
      end else begin
         gen_q     <= gen_d;
         exp_q     <= exp_d;
         out_cnt_q <= out_cnt_d;
         in_cnt_q  <= in_cnt_d;
         err_q     <= err_d;
         thr_in_q  <= thr_in_d;
         thr_out_q <= thr_out_d;
         in_rdy_q  <= thr_in_d[0];
         out_rdy_q <= thr_out_d[0];
      end
   end

   assign out_data       = gen_q;
   assign out_word_count = out_cnt_q;
   assign in_word_count  = in_cnt_q;
   assign error_count    = err_q;
   assign in_ready       = in_rdy_q;
   assign out_ready      = out_rdy_q;

`ifdef PIPE_ENGINE_FIRST_ERR_EN
   logic                  fe_valid_q, fe_valid_d;
   logic [31:0]           fe_idx_q, fe_idx_d;
   logic [DATA_WIDTH-1:0] fe_exp_q, fe_exp_d;
   logic [DATA_WIDTH-1:0] fe_rcv_q, fe_rcv_d;

   // Capture only the first mismatch since reset.
   always_comb begin
      fe_valid_d = fe_valid_q;
      fe_idx_d   = fe_idx_q;
      fe_exp_d   = fe_exp_q;
      fe_rcv_d   = fe_rcv_q;
      if (in_write && mismatch && !fe_valid_q) begin
         fe_valid_d = 1'b1;
         fe_idx_d   = in_cnt_q;
         fe_exp_d   = exp_q;
         fe_rcv_d   = in_data;
      end
   end

   // First-error capture registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         fe_valid_q <= 1'b0;
         fe_idx_q   <= '0;
         fe_exp_q   <= '0;
         fe_rcv_q   <= '0;
      end else begin
         fe_valid_q <= fe_valid_d;
         fe_idx_q   <= fe_idx_d;
         fe_exp_q   <= fe_exp_d;
         fe_rcv_q   <= fe_rcv_d;
      end
   end

   assign first_err_valid    = fe_valid_q;
   assign first_err_index    = fe_idx_q;
   assign first_err_expected = fe_exp_q;
   assign first_err_received = fe_rcv_q;
`else
   assign first_err_valid    = 1'b0;
   assign first_err_index    = '0;
   assign first_err_expected = '0;
   assign first_err_received = '0;
`endif

endmodule

// File: tb/tb_pipe_pattern_engine.sv
// Directed bench for pipe_pattern_engine at DATA_WIDTH=64.
// First-error checks follow PIPE_ENGINE_FIRST_ERR_EN.
module tb_pipe_pattern_engine;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [2:0]    pattern = 3'd0;
   logic          throttle_set = 1'b0;
   logic [31:0]   throttle_in_val = '0;
   logic [31:0]   throttle_out_val = '0;
   logic          in_write = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_read = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic [31:0]   error_count;
   logic [31:0]   in_word_count;
   logic [31:0]   out_word_count;
   logic          first_err_valid;
   logic [31:0]   first_err_index;
   logic [DW-1:0] first_err_expected;
   logic [DW-1:0] first_err_received;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_pattern_engine #(.DATA_WIDTH(DW)) dut (
      .clk(clk),
      .reset(reset),
      .pattern(pattern),
      .throttle_set(throttle_set),
      .throttle_in_val(throttle_in_val),
      .throttle_out_val(throttle_out_val),
      .in_write(in_write),
      .in_data(in_data),
      .in_ready(in_ready),
      .out_read(out_read),
      .out_data(out_data),
      .out_ready(out_ready),
      .error_count(error_count),
      .in_word_count(in_word_count),
      .out_word_count(out_word_count),
      .first_err_valid(first_err_valid),
      .first_err_index(first_err_index),
      .first_err_expected(first_err_expected),
      .first_err_received(first_err_received)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [63:0] wdata;
      logic [63:0] exp_out;
      logic [31:0] exp_err;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset(input logic [2:0] p);
      @(negedge clk);
      reset = 1'b1;
      pattern = p;
      out_read = 1'b0;
      in_write = 1'b0;
      throttle_set = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      pattern = 3'd6;
   endtask

   task automatic reads(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         out_read = 1'b1;
      end
      @(negedge clk);
      out_read = 1'b0;
   endtask

   logic [31:0] m_in;
   logic [31:0] m_out;

   initial begin
      vecs[0] = '{1'b1, 1'b1, 64'h00000001_00000000, 64'h00000003_00000002, 32'd0};
      vecs[1] = '{1'b1, 1'b1, 64'h00000003_00000002, 64'h00000005_00000004, 32'd0};
      vecs[2] = '{1'b1, 1'b1, 64'hDEADBEEF_00000004, 64'h00000007_00000006, 32'd1};
      vecs[3] = '{1'b1, 1'b1, 64'h00000007_00000006, 64'h00000009_00000008, 32'd1};
      vecs[4] = '{1'b0, 1'b1, 64'h00000009_00000008, 64'h00000009_00000008, 32'd1};
      vecs[5] = '{1'b0, 1'b1, 64'h0000000B_0000000A, 64'h00000009_00000008, 32'd1};
      vecs[6] = '{1'b0, 1'b1, 64'h0000000D_0000000C, 64'h00000009_00000008, 32'd1};
      vecs[7] = '{1'b0, 1'b1, 64'h0000000F_0000000E, 64'h00000009_00000008, 32'd1};

      // Count pattern: reset state, then table of reads/writes.
      do_reset(3'd0);
      check("rst_out_data", out_data, 64'h00000001_00000000);
      check("rst_err", 64'(error_count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_ready", 64'(out_ready), 64'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         out_read = vecs[i].rd;
         in_write = vecs[i].wr;
         in_data = vecs[i].wdata;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_out", i), out_data, vecs[i].exp_out);
         check($sformatf("vec%0d_err", i), 64'(error_count),
               64'(vecs[i].exp_err));
      end
      @(negedge clk);
      out_read = 1'b0;
      in_write = 1'b0;
      check("cnt_out_words", 64'(out_word_count), 64'd4);
      check("cnt_in_words", 64'(in_word_count), 64'd8);
`ifdef PIPE_ENGINE_FIRST_ERR_EN
      check("fe_valid", 64'(first_err_valid), 64'd1);
      check("fe_index", 64'(first_err_index), 64'd2);
      check("fe_expected", first_err_expected, 64'h00000005_00000004);
      check("fe_received", first_err_received, 64'hDEADBEEF_00000004);
`else
      check("fe_valid_off", 64'(first_err_valid), 64'd0);
      check("fe_index_off", 64'(first_err_index), 64'd0);
`endif

      // LFSR: seeds, one step, then 1000-word loopback.
      do_reset(3'd1);
      check("lfsr_w0", out_data, 64'h0D0C0B0B_0D0C0B0A);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         in_data = out_data;
         in_write = 1'b1;
         out_read = 1'b1;
         @(posedge clk);
         #1;
         if (i == 0)
            check("lfsr_w1", out_data, 64'h1A181616_1A181615);
      end
      @(negedge clk);
      in_write = 1'b0;
      out_read = 1'b0;
      check("lfsr_loop_err", 64'(error_count), 64'd0);
      check("lfsr_in_words", 64'(in_word_count), 64'd1000);
      check("lfsr_out_words", 64'(out_word_count), 64'd1000);

      // Throttle masks walk bit 0 upward with period 32.
      m_in = 32'h0000000F;
      m_out = 32'hC0000001;
      @(negedge clk);
      throttle_set = 1'b1;
      throttle_in_val = m_in;
      throttle_out_val = m_out;
      @(posedge clk);
      #1;
      check("thr_in_0", 64'(in_ready), 64'(m_in[0]));
      check("thr_out_0", 64'(out_ready), 64'(m_out[0]));
      @(negedge clk);
      throttle_set = 1'b0;
      for (int k = 1; k < 64; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("thr_in_%0d", k), 64'(in_ready), 64'(m_in[k % 32]));
         check($sformatf("thr_out_%0d", k), 64'(out_ready), 64'(m_out[k % 32]));
      end

      // Reset beats throttle_set in the same cycle.
      @(negedge clk);
      reset = 1'b1;
      pattern = 3'd0;
      throttle_set = 1'b1;
      throttle_in_val = 32'h0;
      throttle_out_val = 32'h0;
      @(posedge clk);
      #1;
      check("prio_in_ready", 64'(in_ready), 64'd1);
      check("prio_out_ready", 64'(out_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      throttle_set = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("prio_ones_in", 64'(in_ready), 64'd1);
         check("prio_ones_out", 64'(out_ready), 64'd1);
      end

      // Walking-one, errors, then reset mid-transfer.
      do_reset(3'd2);
      check("walk_w0", out_data, 64'h00000002_00000001);
      reads(10);
      check("walk_w10", out_data, 64'h00000800_00000400);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_data = '0;
         in_write = 1'b1;
      end
      @(negedge clk);
      in_write = 1'b0;
      check("walk_err", 64'(error_count), 64'd3);
`ifdef PIPE_ENGINE_FIRST_ERR_EN
      check("walk_fe_valid", 64'(first_err_valid), 64'd1);
      check("walk_fe_exp", first_err_expected, 64'h00000002_00000001);
`endif
      do_reset(3'd2);
      check("rst2_out", out_data, 64'h00000002_00000001);
      check("rst2_err", 64'(error_count), 64'd0);
      check("rst2_in_words", 64'(in_word_count), 64'd0);
      check("rst2_out_words", 64'(out_word_count), 64'd0);
      check("rst2_fe_valid", 64'(first_err_valid), 64'd0);
      check("rst2_fe_index", 64'(first_err_index), 64'd0);

      // Alternating pattern and an out-of-range code.
      do_reset(3'd3);
      check("alt_w0", out_data, 64'hA5A55A5A_A5A55A5A);
      reads(1);
      check("alt_w1", out_data, 64'h5A5AA5A5_5A5AA5A5);
      reads(1);
      check("alt_w2", out_data, 64'hA5A55A5A_A5A55A5A);
      do_reset(3'd5);
      check("pat5_w0", out_data, 64'h00000001_00000000);
      reads(1);
      check("pat5_w1", out_data, 64'h00000003_00000002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
